// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation codes (MULT/MULTU/DIV/DIVU) and FSM state constants.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative (1 bit/cycle) MULT/MULTU/DIV/DIVU unit producing HI/LO.
// Ports: clk, rst_n, start/op/a/b/flush in; busy/done/hi/lo/div_zero out.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               neg_q, neg_d;
  logic               nrem_q, nrem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dzo_q, dzo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     m_sum;
  logic [WIDTH:0]     d_shl, d_dif;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Unsigned ops never see a negative operand, so signs stay clear.
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  assign m_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, opa_q} : '0);

  // Restoring divide: acc[W-1:0] shifts dividend out, quotient in.
  assign d_shl = {rem_q, acc_q[WIDTH-1]};
  assign d_dif = d_shl - {1'b0, opb_q};

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = nrem_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    nrem_d  = nrem_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dzo_d   = dzo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_CALC;
          op_d    = op;
          cnt_d   = '0;
          rem_d   = '0;
          neg_d   = a_neg ^ b_neg;
          nrem_d  = a_neg;
          dz_d    = op[1] & (b == '0);
          opb_d   = b_mag;
          if (op[1]) begin
            // Divide keeps raw a for the divide-by-zero result.
            opa_d = a;
            acc_d = {{WIDTH{1'b0}}, a_mag};
          end else begin
            opa_d = a_mag;
            acc_d = {{WIDTH{1'b0}}, b_mag};
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[1]) begin
            rem_d = d_dif[WIDTH] ? d_shl[WIDTH-1:0]
                                 : d_dif[WIDTH-1:0];
            acc_d = {acc_q[2*WIDTH-1:WIDTH],
                     acc_q[WIDTH-2:0], ~d_dif[WIDTH]};
          end else begin
            acc_d = {m_sum, acc_q[WIDTH-1:1]};
          end
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          dzo_d   = dz_q;
          if (dz_q) begin
            hi_d = opa_q;
            lo_d = '1;
          end else if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      nrem_q  <= nrem_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dzo_q   <= dzo_d;
    end
  end

  assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dzo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (WIDTH=32).
// Directed vectors; monitor pops expected results on each done.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         flush;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
    string        nm;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: every done pops one expected result.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'(cyc), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk({e.nm, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.nm, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.nm, "_dz"}, 64'(div_zero), 64'(e.dz));
        chk({e.nm, "_lat"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drive_start(input logic [1:0] o,
                             input logic [W-1:0] x,
                             input logic [W-1:0] y,
                             output int acc);
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(n), 64'(0));
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
  endtask

  task automatic issue(input string nm, input logic [1:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic ed);
    int acc;
    exp_t e;
    drive_start(o, x, y, acc);
    e.hi = eh;
    e.lo = el;
    e.dz = ed;
    e.cyc = acc + LAT;
    e.nm = nm;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("done_timeout", 64'(n), 64'(0));
  endtask

  task automatic run(input string nm, input logic [1:0] o,
                     input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] eh, input logic [W-1:0] el,
                     input logic ed);
    int prev;
    prev = done_cnt;
    issue(nm, o, x, y, eh, el, ed);
    wait_done(prev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int prev;
    int acc;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_dz", 64'(div_zero), 64'(0));
    rst_n = 1'b1;

    run("mult_neg3x5", OP_MULT, 32'hFFFFFFFD, 32'd5,
        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("mult_m1m1", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'h0, 32'h1, 1'b0);
    run("mult_minmin", OP_MULT, 32'h80000000, 32'h80000000,
        32'h40000000, 32'h0, 1'b0);
    run("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE,
        32'h1, 32'hFFFFFFFD, 1'b0);
    run("divu_100_7", OP_DIVU, 32'd100, 32'd7,
        32'd2, 32'd14, 1'b0);
    run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
        32'h0, 32'h80000000, 1'b0);
    run("divu_by0", OP_DIVU, 32'd100, 32'd0,
        32'd100, 32'hFFFFFFFF, 1'b1);
    run("multu_2x3", OP_MULTU, 32'd2, 32'd3,
        32'd0, 32'd6, 1'b0);
    run("div_m7_by0", OP_DIV, 32'hFFFFFFF9, 32'd0,
        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

    // Second start while busy must be dropped.
    prev = done_cnt;
    issue("divu_dbl", OP_DIVU, 32'd1000, 32'd10,
          32'd0, 32'd100, 1'b0);
    repeat (9) @(negedge clk);
    op = OP_MULTU;
    a = 32'd5;
    b = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(prev);
    repeat (LAT + 6) @(negedge clk);
    chk("dbl_one_done", 64'(done_cnt), 64'(prev + 1));
    chk("dbl_busy", 64'(busy), 64'(0));

    // Flush mid-CALC: no done, outputs retained.
    prev = done_cnt;
    drive_start(OP_MULT, 32'd7, 32'd7, acc);
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'(0));
    repeat (LAT + 6) @(negedge clk);
    chk("flush_no_done", 64'(done_cnt), 64'(prev));
    chk("flush_hi", 64'(hi), 64'(0));
    chk("flush_lo", 64'(lo), 64'(100));

    // Asynchronous reset mid-CALC.
    prev = done_cnt;
    drive_start(OP_MULTU, 32'd9, 32'd9, acc);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    chk("arst_dz", 64'(div_zero), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    chk("arst_no_done", 64'(done_cnt), 64'(prev));
    run("multu_3x4", OP_MULTU, 32'd3, 32'd4,
        32'd0, 32'd12, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
